// File: rtl/event_sort_queue.sv
`default_nettype none
// ============================================================================
// Module   : event_sort_queue
// Purpose  : Sorted pending-event store. Keeps up to DEPTH messages in
//            ascending timestamp order (key = data[CMP_WID-1:0], unsigned).
//            Equal keys retain arrival order. The head (minimum key) is
//            presented with zero read latency. The structure is a systolic
//            insertion array that accepts one enqueue and one dequeue per
//            cycle.
// Ports    : clk, rst_n     - clock, asynchronous active-low reset
//            flush          - synchronous clear of all slots (highest priority)
//            enq, inp_data  - insert inp_data this cycle
//            deq            - remove head this cycle
//            out_data       - head event, 0 when empty
//            full, empty    - derived from the registered elem_cnt
//            elem_cnt       - number of valid slots
//            ovf, udf       - sticky: enq dropped when full / deq when empty
// Revision : 1.0 - initial release
// ============================================================================
module event_sort_queue #(
  parameter int MSG_WID = 32,
  parameter int CMP_WID = 16,
  parameter int DEPTH   = 24,
  parameter int CNT_WID = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               enq,
  input  logic               deq,
  input  logic [MSG_WID-1:0] inp_data,
  output logic [MSG_WID-1:0] out_data,
  output logic               full,
  output logic               empty,
  output logic [CNT_WID-1:0] elem_cnt,
  output logic               ovf,
  output logic               udf
);

  localparam logic [CNT_WID-1:0] CNT_FULL = CNT_WID'(DEPTH);

  logic [MSG_WID-1:0] slot_data [DEPTH];
  logic [DEPTH-1:0]   slot_vld;

  logic               deq_e;
  logic               enq_e;
  logic [CMP_WID-1:0] new_key;

  // ins[i] = 1 when the new entry belongs at or before slot i, i.e. the slot
  // is empty or holds a strictly larger key. Because valid slots are
  // contiguous and sorted, ins is a thermometer code (0..0 1..1), so each
  // slot can decide its move from its own bit and its neighbours' bits.
  // ins[DEPTH] is a virtual always-empty slot past the end.
  logic [DEPTH:0]     ins;

  assign full     = (elem_cnt == CNT_FULL);
  assign empty    = (elem_cnt == '0);
  assign deq_e    = deq & ~empty;
  assign enq_e    = enq & (~full | deq_e);
  assign new_key  = inp_data[CMP_WID-1:0];
  assign out_data = slot_data[0];
  assign ins[DEPTH] = 1'b1;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      logic [MSG_WID-1:0] below_data;
      logic               below_vld;
      logic               below_ins;
      logic [MSG_WID-1:0] above_data;
      logic               above_vld;
      logic               hold_sim;

      assign ins[i] = ~slot_vld[i] | (slot_data[i][CMP_WID-1:0] > new_key);

      if (i == 0) begin : g_bottom
        assign below_data = '0;
        assign below_vld  = 1'b0;
        assign below_ins  = 1'b0;
        // The head is always discarded on a simultaneous enq/deq, so it
        // never holds its value in that case.
        assign hold_sim   = 1'b0;
      end else begin : g_inner
        assign below_data = slot_data[i-1];
        assign below_vld  = slot_vld[i-1];
        assign below_ins  = ins[i-1];
        assign hold_sim   = ins[i];
      end

      if (i == DEPTH - 1) begin : g_top
        assign above_data = '0;
        assign above_vld  = 1'b0;
      end else begin : g_lower
        assign above_data = slot_data[i+1];
        assign above_vld  = slot_vld[i+1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_vld[i]  <= 1'b0;
          slot_data[i] <= '0;
        end else if (flush) begin
          slot_vld[i]  <= 1'b0;
          slot_data[i] <= '0;
        end else if (enq_e && deq_e) begin
          // Shift down below the insertion point; the slot just under the
          // first larger key takes the new entry; slots above stay put.
          if (!hold_sim) begin
            if (ins[i+1]) begin
              slot_vld[i]  <= 1'b1;
              slot_data[i] <= inp_data;
            end else begin
              slot_vld[i]  <= above_vld;
              slot_data[i] <= above_data;
            end
          end
        end else if (enq_e) begin
          // Slots at/after the insertion point shift up by one; the
          // insertion point itself is where ins first becomes 1.
          if (ins[i]) begin
            if (below_ins) begin
              slot_vld[i]  <= below_vld;
              slot_data[i] <= below_data;
            end else begin
              slot_vld[i]  <= 1'b1;
              slot_data[i] <= inp_data;
            end
          end
        end else if (deq_e) begin
          slot_vld[i]  <= above_vld;
          slot_data[i] <= above_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_cnt <= '0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else if (flush) begin
      elem_cnt <= '0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      if (enq_e && !deq_e) begin
        elem_cnt <= elem_cnt + 1'b1;
      end else if (deq_e && !enq_e) begin
        elem_cnt <= elem_cnt - 1'b1;
      end
      if (enq && !enq_e) begin
        ovf <= 1'b1;
      end
      if (deq && empty) begin
        udf <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_event_sort_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_event_sort_queue
// Purpose  : Self-checking bench for event_sort_queue. A sorted-list model
//            holds the expected contents; dequeued heads are popped from it
//            and compared against the DUT, and the observable state is
//            compared after every clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_event_sort_queue;

  localparam int MSG_WID = 32;
  localparam int CMP_WID = 16;
  localparam int DEPTH   = 24;
  localparam int CNT_WID = $clog2(DEPTH + 1);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               flush = 1'b0;
  logic               enq = 1'b0;
  logic               deq = 1'b0;
  logic [MSG_WID-1:0] inp_data = '0;
  logic [MSG_WID-1:0] out_data;
  logic               full;
  logic               empty;
  logic [CNT_WID-1:0] elem_cnt;
  logic               ovf;
  logic               udf;

  event_sort_queue #(
    .MSG_WID (MSG_WID),
    .CMP_WID (CMP_WID),
    .DEPTH   (DEPTH),
    .CNT_WID (CNT_WID)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .enq      (enq),
    .deq      (deq),
    .inp_data (inp_data),
    .out_data (out_data),
    .full     (full),
    .empty    (empty),
    .elem_cnt (elem_cnt),
    .ovf      (ovf),
    .udf      (udf)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] mq[$];
  bit          m_ovf = 1'b0;
  bit          m_udf = 1'b0;
  int unsigned seq = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // New entry goes after every entry whose key is <= its own key.
  task automatic model_insert(input logic [31:0] v);
    int idx;
    idx = mq.size();
    for (int k = 0; k < mq.size(); k++) begin
      if (mq[k][CMP_WID-1:0] > v[CMP_WID-1:0]) begin
        idx = k;
        break;
      end
    end
    mq.insert(idx, v);
  endtask

  task automatic check_state(input string tag);
    logic [31:0] exp_head;
    exp_head = (mq.size() > 0) ? mq[0] : 32'h0;
    chk({tag, ".cnt"},   32'(elem_cnt), 32'(mq.size()));
    chk({tag, ".head"},  out_data,      exp_head);
    chk({tag, ".empty"}, 32'(empty),    32'(mq.size() == 0));
    chk({tag, ".full"},  32'(full),     32'(mq.size() == DEPTH));
    chk({tag, ".ovf"},   32'(ovf),      32'(m_ovf));
    chk({tag, ".udf"},   32'(udf),      32'(m_udf));
  endtask

  // One clock with the given strobes; inputs change 1 time unit after the
  // active edge and outputs are sampled there as well.
  task automatic step(input bit e, input bit d, input logic [31:0] din, input string tag);
    logic [31:0] head_before;
    logic [31:0] popped;
    bit          deq_e;
    bit          enq_e;
    head_before = out_data;
    enq      = e;
    deq      = d;
    inp_data = din;
    @(posedge clk);
    #1;
    enq = 1'b0;
    deq = 1'b0;
    deq_e = d && (mq.size() > 0);
    enq_e = e && ((mq.size() < DEPTH) || deq_e);
    if (d && mq.size() == 0) m_udf = 1'b1;
    if (e && !enq_e)         m_ovf = 1'b1;
    if (deq_e) begin
      popped = mq.pop_front();
      chk({tag, ".pop"}, head_before, popped);
    end
    if (enq_e) model_insert(din);
    check_state(tag);
  endtask

  task automatic model_clear();
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    rst_n = 1'b1;

    // Ordering with a duplicate key; the tagged 10 must come out second.
    step(1, 0, 32'd50, "ord_enq");
    step(1, 0, 32'd10, "ord_enq");
    step(1, 0, 32'd30, "ord_enq");
    step(1, 0, 32'h0001_000A, "ord_enq");
    for (int k = 0; k < 4; k++) step(0, 1, 32'h0, "ord_deq");

    // Fill to capacity, overflow, then replace head while full.
    for (int k = 100; k < 124; k++) step(1, 0, 32'(k), "fill");
    step(1, 0, 32'd5, "ovf_drop");
    step(1, 1, 32'd5, "full_swap");
    for (int k = 0; k < DEPTH; k++) step(0, 1, 32'h0, "drain_full");

    // Simultaneous enq/deq into the middle and at the head.
    step(1, 0, 32'd20, "sim_setup");
    step(1, 0, 32'd40, "sim_setup");
    step(1, 1, 32'd30, "sim_mid");
    step(1, 1, 32'd10, "sim_head");
    step(0, 1, 32'h0, "sim_drain");
    step(0, 1, 32'h0, "sim_drain");

    // Underflow, then enq+deq on an empty queue behaves as enqueue only.
    step(0, 1, 32'h0, "udf");
    step(1, 1, 32'd7, "udf_enq");

    // Flush with a concurrent enq.
    for (int k = 0; k < 5; k++) step(1, 0, 32'(60 + k), "flush_setup");
    flush    = 1'b1;
    enq      = 1'b1;
    inp_data = 32'd99;
    @(posedge clk);
    #1;
    flush = 1'b0;
    enq   = 1'b0;
    model_clear();
    check_state("flush");

    // Asynchronous reset mid-operation.
    for (int k = 0; k < 12; k++) step(1, 0, 32'(200 - k), "arst_setup");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.cnt_now",  32'(elem_cnt), 32'h0);
    chk("arst.head_now", out_data,      32'h0);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_state("arst_rel");
    step(1, 0, 32'd3, "arst_enq");
    step(0, 1, 32'h0, "arst_deq");

    // Random traffic with heavy key collisions; the upper bits carry a
    // sequence tag so FIFO order among equal keys is visible.
    for (int n = 0; n < 10000; n++) begin
      int          p_enq;
      bit          e;
      bit          d;
      logic [31:0] v;
      p_enq = ((n / 500) % 2 == 0) ? 70 : 30;
      e = ($urandom_range(0, 99) < p_enq);
      d = ($urandom_range(0, 99) < (100 - p_enq));
      seq++;
      v = {16'(seq), 16'($urandom_range(0, 15))};
      step(e, d, v, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
